if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//   Instruction-fetch front end. Consumes the registered jump/flush outputs of the control unit.
//   Holds the PC and issues in-order requests on a req/gnt/rvalid instruction-memory port.
//   Buffers returned instructions and hands them to decode on a valid/ready interface.
//   On jump or flush, kills in-flight fetches and restarts from the correct address.
// PARAMETERS
//   ADDR_WIDTH  32            PC / memory address width
//   DATA_WIDTH  32            instruction width
//   RST_PC      32'h0000_0000 first fetch address after reset
//   BUF_DEPTH   2             instruction buffer entries; also max outstanding requests (power of 2, >=2)
// PORTS
//   clk               in   1           clock, all state on rising edge
//   rst               in   1           reset, asynchronous, active-high
//   jump_en_i         in   1           redirect PC to jump_addr_i this cycle
//   jump_addr_i       in   ADDR_WIDTH  redirect target
//   pipeline_flush_i  in   1           discard buffered/in-flight fetches, replay
//   imem_req_o        out  1           fetch request valid
//   imem_addr_o       out  ADDR_WIDTH  fetch address (word aligned)
//   imem_gnt_i        in   1           request accepted (counts only when imem_req_o=1)
//   imem_rvalid_i     in   1           response valid, in request order, >=1 cycle after gnt
//   imem_rdata_i      in   DATA_WIDTH  response instruction
//   inst_valid_o      out  1           instruction available to decode
//   inst_o            out  DATA_WIDTH  buffer head; 32'h0000_0013 (NOP) when empty
//   inst_addr_o       out  ADDR_WIDTH  PC of inst_o; 0 when empty
//   inst_ready_i      in   1           decode accepts head when inst_valid_o=1
// BEHAVIOUR
//   Reset (async):
//     pc=RST_PC, replay_pc=RST_PC, outstanding=0, discard=0, buffer empty.
//     imem_req_o=0, inst_valid_o=0, inst_o=NOP, inst_addr_o=0.
//     Memory is reset with this block; no stale responses follow reset.
//   Request:
//     imem_req_o=1 when (outstanding+count)<BUF_DEPTH and no jump/flush this cycle.
//     imem_addr_o=pc, always word aligned.
//     Once raised, req and addr hold stable until gnt, unless a jump or flush occurs.
//     On req&gnt: pc+=4 (wraps modulo 2^ADDR_WIDTH), and pc is pushed into an address queue (depth BUF_DEPTH).
//   Response:
//     On rvalid with discard==0: pop the address queue and write {addr,rdata} into the buffer.
//     Space is guaranteed by the request rule. rvalid with outstanding==0 is a protocol error: ignore it and leave state unchanged.
//   outstanding: +1 on gnt, -1 on rvalid; both in the same cycle = no change; range 0..BUF_DEPTH.
//   Output:
//     inst_valid_o = buffer non-empty and no jump/flush this cycle.
//     Pop on inst_valid_o & inst_ready_i; replay_pc <= popped addr+4.
//     Minimum latency: gnt in cycle N, rvalid N+1, inst_valid_o N+2.
//     Push and pop in the same cycle with a full buffer is legal.
//   Jump (jump_en_i=1):
//     pc <= {jump_addr_i[ADDR_WIDTH-1:2],2'b00}; replay_pc <= same.
//     Buffer cleared; address queue cleared.
//     discard <= outstanding - (rvalid?1:0). The same-cycle response is dropped.
//     imem_req_o and inst_valid_o forced 0 in that cycle; the first request goes out the next cycle.
//   Flush only (pipeline_flush_i=1, jump_en_i=0):
//     Same kill actions as a jump, but pc <= replay_pc (next instruction after the last one consumed).
//   Jump and flush together: jump wins.
//   Any response arriving while discard>0 is dropped and decrements discard.
//   New requests are allowed while discard>0 (outstanding still counts killed fetches).
//   A back-to-back jump while discard>0 reloads discard from outstanding (same formula).
// TESTING
//   T1 reset, gnt=1 always, rvalid 1 cycle after gnt, ready=1 ->
//      addr 0,4,8.. in consecutive cycles; inst_valid_o first high 2 cycles after first gnt; inst_addr_o tracks 0,4,8.
//   T2 ready=0 for 6 cycles ->
//      exactly 2 requests issued, req drops, buffer holds addr 0 and 4;
//      release ready -> order preserved, no duplicates or skips.
//   T3 jump_en_i=1 with jump_addr_i=0x100 and 2 fetches in flight ->
//      req=0 that cycle; next req addr 0x100; both old responses dropped; first delivered inst_addr_o=0x100.
//   T4 jump_addr_i=0x103 -> fetch address 0x100.
//   T5 flush only after decode consumed addr 0x8 ->
//      buffer emptied; refetch starts at 0xC; 0xC delivered once.
//   T6 jump+flush same cycle (addr 0x40), plus rvalid in that cycle ->
//      jump target used; response dropped; discard reaches 0 after the remaining response.
//   T7 assert rst mid-burst -> all outputs at reset values immediately; after release, first req addr=RST_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC, in-order req/gnt/rvalid fetch port, instruction buffer to decode.
// Jump/flush kill in-flight fetches; killed responses are counted off by a discard counter.
module if_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RST_PC     = '0,
  parameter int                    BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jump_en_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  pipeline_flush_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  inst_valid_o,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_addr_o,
  input  logic                  inst_ready_i
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DATA_WIDTH-1:0] NOP       = DATA_WIDTH'(32'h0000_0013);
  localparam logic [ADDR_WIDTH-1:0] RST_PC_AL = {RST_PC[ADDR_WIDTH-1:2], 2'b00};

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] replay_pc;
  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      discard;

  // Address queue: PC of each live (non-killed) granted fetch, in request order.
  logic [ADDR_WIDTH-1:0] aq_mem [BUF_DEPTH];
  logic [CNT_W-1:0]      aq_wr;
  logic [CNT_W-1:0]      aq_rd;

  // Instruction buffer: {addr, data} pairs awaiting decode.
  logic [ADDR_WIDTH-1:0] ba_mem [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] bd_mem [BUF_DEPTH];
  logic [CNT_W-1:0]      b_wr;
  logic [CNT_W-1:0]      b_rd;

  logic                  kill;
  logic [ADDR_WIDTH-1:0] jump_tgt;
  logic [CNT_W-1:0]      buf_count;
  logic                  buf_empty;
  logic [CNT_W:0]        in_use;
  logic                  req_fire;
  logic                  rsp_ok;
  logic                  rsp_keep;
  logic                  rsp_drop;
  logic                  pop;
  logic [PTR_W-1:0]      head;
  logic [1:0]            unused_jump_lsb;

  assign unused_jump_lsb = jump_addr_i[1:0];

  assign kill      = jump_en_i | pipeline_flush_i;
  assign jump_tgt  = {jump_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign buf_count = b_wr - b_rd;
  assign buf_empty = (buf_count == '0);
  assign in_use    = {1'b0, outstanding} + {1'b0, buf_count};
  assign head      = b_rd[PTR_W-1:0];

  // Issue only when every outstanding fetch is guaranteed a buffer slot.
  assign imem_req_o  = !rst && !kill && (in_use < (CNT_W+1)'(BUF_DEPTH));
  assign imem_addr_o = pc;
  assign req_fire    = imem_req_o & imem_gnt_i;

  // A response with nothing outstanding is a protocol error and is ignored entirely.
  assign rsp_ok   = imem_rvalid_i && (outstanding != '0);
  assign rsp_keep = rsp_ok && !kill && (discard == '0);
  assign rsp_drop = rsp_ok && !kill && (discard != '0);

  assign inst_valid_o = !buf_empty && !kill;
  assign pop          = inst_valid_o & inst_ready_i;
  assign inst_o       = buf_empty ? NOP : bd_mem[head];
  assign inst_addr_o  = buf_empty ? '0  : ba_mem[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RST_PC_AL;
      replay_pc   <= RST_PC_AL;
      outstanding <= '0;
      discard     <= '0;
      aq_wr       <= '0;
      aq_rd       <= '0;
      b_wr        <= '0;
      b_rd        <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_ok);
      if (kill) begin
        // Every fetch still outstanding after this cycle belongs to the old stream.
        discard <= outstanding - CNT_W'(rsp_ok);
        aq_wr   <= '0;
        aq_rd   <= '0;
        b_wr    <= '0;
        b_rd    <= '0;
        if (jump_en_i) begin
          pc        <= jump_tgt;
          replay_pc <= jump_tgt;
        end else begin
          pc <= replay_pc;
        end
      end else begin
        if (req_fire) begin
          pc    <= pc + ADDR_WIDTH'(4);
          aq_wr <= aq_wr + CNT_W'(1);
        end
        if (rsp_drop) begin
          discard <= discard - CNT_W'(1);
        end
        if (rsp_keep) begin
          aq_rd <= aq_rd + CNT_W'(1);
          b_wr  <= b_wr + CNT_W'(1);
        end
        if (pop) begin
          b_rd      <= b_rd + CNT_W'(1);
          replay_pc <= ba_mem[head] + ADDR_WIDTH'(4);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      aq_mem[aq_wr[PTR_W-1:0]] <= pc;
    end
    if (rsp_keep) begin
      ba_mem[b_wr[PTR_W-1:0]] <= aq_mem[aq_rd[PTR_W-1:0]];
      bd_mem[b_wr[PTR_W-1:0]] <= imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: queue-based memory model, monitor of grants and deliveries.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        pipeline_flush_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic mem_en;

  logic [31:0] pend[$];
  logic [31:0] reqs[$];
  logic [31:0] got_a[$];
  logic [31:0] got_d[$];
  int          gnt_cyc[$];
  int          val_cyc[$];

  if_fetch_unit #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RST_PC(32'h0000_0000), .BUF_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i), .pipeline_flush_i(pipeline_flush_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .inst_ready_i(inst_ready_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: capture grants mid-cycle, answer in order no earlier than the next cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && imem_req_o && imem_gnt_i) pend.push_back(imem_addr_o);
    end
  end

  initial begin
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        pend.delete();
        imem_rvalid_i = 1'b0;
      end else if (mem_en && pend.size() > 0) begin
        logic [31:0] a;
        a = pend.pop_front();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hA000_0000 | a;
      end else begin
        imem_rvalid_i = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (imem_req_o && imem_gnt_i) begin
          reqs.push_back(imem_addr_o);
          gnt_cyc.push_back(cyc);
        end
        if (inst_valid_o && inst_ready_i) begin
          got_a.push_back(inst_addr_o);
          got_d.push_back(inst_o);
          val_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic clear_logs();
    reqs.delete(); got_a.delete(); got_d.delete(); gnt_cyc.delete(); val_cyc.delete();
  endtask

  // Leaves the caller at cycle 0 (1 time unit after the first edge with rst low).
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; jump_en_i = 1'b0; jump_addr_i = '0; pipeline_flush_i = 1'b0;
    imem_gnt_i = 1'b0; inst_ready_i = 1'b0; mem_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%h exp=0", imem_req_o); end
    checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%h exp=0", inst_valid_o); end
    checks++; if (inst_o !== 32'h0000_0013) begin failures++; $display("FAIL reset_inst got=%h exp=00000013", inst_o); end
    checks++; if (inst_addr_o !== 32'h0) begin failures++; $display("FAIL reset_inst_addr got=%h exp=0", inst_addr_o); end
  endtask

  task automatic test_stream();
    do_reset();
    imem_gnt_i = 1'b1; inst_ready_i = 1'b1;
    repeat (20) @(posedge clk);
    checks++;
    if (reqs.size() < 6 || got_a.size() < 5 || val_cyc.size() < 1) begin
      failures++; $display("FAIL stream_count reqs=%0d got=%0d exp>=6/5", reqs.size(), got_a.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (reqs[i] !== 32'(4*i)) begin failures++; $display("FAIL stream_req%0d got=%h exp=%h", i, reqs[i], 32'(4*i)); end
      end
      checks++; if (gnt_cyc[1] - gnt_cyc[0] != 1) begin failures++; $display("FAIL stream_gnt_gap got=%0d exp=1", gnt_cyc[1] - gnt_cyc[0]); end
      checks++; if (val_cyc[0] - gnt_cyc[0] != 2) begin failures++; $display("FAIL stream_latency got=%0d exp=2", val_cyc[0] - gnt_cyc[0]); end
      for (int i = 0; i < 5; i++) begin
        checks++; if (got_a[i] !== 32'(4*i)) begin failures++; $display("FAIL stream_addr%0d got=%h exp=%h", i, got_a[i], 32'(4*i)); end
        checks++; if (got_d[i] !== (32'hA000_0000 | 32'(4*i))) begin failures++; $display("FAIL stream_data%0d got=%h exp=%h", i, got_d[i], 32'hA000_0000 | 32'(4*i)); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    imem_gnt_i = 1'b1; inst_ready_i = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++; if (reqs.size() != 2) begin failures++; $display("FAIL bp_req_count got=%0d exp=2", reqs.size()); end
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL bp_req_drop got=%h exp=0", imem_req_o); end
    checks++; if (inst_valid_o !== 1'b1) begin failures++; $display("FAIL bp_valid got=%h exp=1", inst_valid_o); end
    checks++; if (inst_addr_o !== 32'h0) begin failures++; $display("FAIL bp_head_addr got=%h exp=0", inst_addr_o); end
    checks++; if (inst_o !== 32'hA000_0000) begin failures++; $display("FAIL bp_head_data got=%h exp=a0000000", inst_o); end
    @(posedge clk); #1;
    inst_ready_i = 1'b1;
    repeat (10) @(posedge clk);
    checks++;
    if (got_a.size() < 4) begin
      failures++; $display("FAIL bp_release_count got=%0d exp>=4", got_a.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (got_a[i] !== 32'(4*i)) begin failures++; $display("FAIL bp_order%0d got=%h exp=%h", i, got_a[i], 32'(4*i)); end
      end
    end
  endtask

  task automatic test_jump_inflight();
    do_reset();
    imem_gnt_i = 1'b1; inst_ready_i = 1'b1; mem_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    jump_en_i = 1'b1; jump_addr_i = 32'h100;
    @(negedge clk);
    checks++; if (reqs.size() != 2) begin failures++; $display("FAIL jmp_inflight got=%0d exp=2", reqs.size()); end
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL jmp_req got=%h exp=0", imem_req_o); end
    @(posedge clk); #1;
    jump_en_i = 1'b0; mem_en = 1'b1;
    clear_logs();
    repeat (10) @(posedge clk);
    checks++;
    if (reqs.size() < 1 || got_a.size() < 2) begin
      failures++; $display("FAIL jmp_count reqs=%0d got=%0d exp>=1/2", reqs.size(), got_a.size());
    end else begin
      checks++; if (reqs[0] !== 32'h100) begin failures++; $display("FAIL jmp_first_req got=%h exp=100", reqs[0]); end
      checks++; if (got_a[0] !== 32'h100) begin failures++; $display("FAIL jmp_first_addr got=%h exp=100", got_a[0]); end
      checks++; if (got_d[0] !== 32'hA000_0100) begin failures++; $display("FAIL jmp_first_data got=%h exp=a0000100", got_d[0]); end
      checks++; if (got_a[1] !== 32'h104) begin failures++; $display("FAIL jmp_second_addr got=%h exp=104", got_a[1]); end
    end
  endtask

  task automatic test_jump_align();
    do_reset();
    imem_gnt_i = 1'b1; inst_ready_i = 1'b1;
    jump_en_i = 1'b1; jump_addr_i = 32'h103;
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL align_req_kill got=%h exp=0", imem_req_o); end
    @(posedge clk); #1;
    jump_en_i = 1'b0;
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b1) begin failures++; $display("FAIL align_req got=%h exp=1", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h100) begin failures++; $display("FAIL align_addr got=%h exp=100", imem_addr_o); end
    repeat (6) @(posedge clk);
    checks++;
    if (got_a.size() < 1) begin
      failures++; $display("FAIL align_count got=%0d exp>=1", got_a.size());
    end else begin
      checks++; if (got_a[0] !== 32'h100) begin failures++; $display("FAIL align_deliver got=%h exp=100", got_a[0]); end
    end
  endtask

  task automatic test_flush();
    bit found;
    int n;
    do_reset();
    imem_gnt_i = 1'b1; inst_ready_i = 1'b1;
    found = 1'b0; n = 0;
    while (!found && n < 40) begin
      @(negedge clk);
      if (inst_valid_o && inst_ready_i && inst_addr_o == 32'h8) found = 1'b1;
      n++;
    end
    checks++; if (!found) begin failures++; $display("FAIL flush_wait8 got=timeout exp=consume 8"); end
    @(posedge clk); #1;
    pipeline_flush_i = 1'b1;
    @(negedge clk);
    checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL flush_valid got=%h exp=0", inst_valid_o); end
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL flush_req got=%h exp=0", imem_req_o); end
    @(posedge clk); #1;
    pipeline_flush_i = 1'b0;
    clear_logs();
    repeat (15) @(posedge clk);
    checks++;
    if (reqs.size() < 1 || got_a.size() < 3) begin
      failures++; $display("FAIL flush_count reqs=%0d got=%0d exp>=1/3", reqs.size(), got_a.size());
    end else begin
      checks++; if (reqs[0] !== 32'hC) begin failures++; $display("FAIL flush_refetch got=%h exp=c", reqs[0]); end
      checks++; if (got_a[0] !== 32'hC) begin failures++; $display("FAIL flush_addr0 got=%h exp=c", got_a[0]); end
      checks++; if (got_d[0] !== 32'hA000_000C) begin failures++; $display("FAIL flush_data0 got=%h exp=a000000c", got_d[0]); end
      checks++; if (got_a[1] !== 32'h10) begin failures++; $display("FAIL flush_addr1 got=%h exp=10", got_a[1]); end
      checks++; if (got_a[2] !== 32'h14) begin failures++; $display("FAIL flush_addr2 got=%h exp=14", got_a[2]); end
    end
  endtask

  task automatic test_jump_flush_rvalid();
    do_reset();
    imem_gnt_i = 1'b1; inst_ready_i = 1'b1; mem_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_en = 1'b1; jump_en_i = 1'b1; pipeline_flush_i = 1'b1; jump_addr_i = 32'h40;
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL jf_req got=%h exp=0", imem_req_o); end
    checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL jf_valid got=%h exp=0", inst_valid_o); end
    @(posedge clk); #1;
    jump_en_i = 1'b0; pipeline_flush_i = 1'b0;
    clear_logs();
    repeat (10) @(posedge clk);
    checks++;
    if (reqs.size() < 1 || got_a.size() < 2) begin
      failures++; $display("FAIL jf_count reqs=%0d got=%0d exp>=1/2", reqs.size(), got_a.size());
    end else begin
      checks++; if (reqs[0] !== 32'h40) begin failures++; $display("FAIL jf_first_req got=%h exp=40", reqs[0]); end
      checks++; if (got_a[0] !== 32'h40) begin failures++; $display("FAIL jf_addr0 got=%h exp=40", got_a[0]); end
      checks++; if (got_d[0] !== 32'hA000_0040) begin failures++; $display("FAIL jf_data0 got=%h exp=a0000040", got_d[0]); end
      checks++; if (got_a[1] !== 32'h44) begin failures++; $display("FAIL jf_addr1 got=%h exp=44", got_a[1]); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    imem_gnt_i = 1'b1; inst_ready_i = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    checks++; if (inst_valid_o !== 1'b1) begin failures++; $display("FAIL ar_pre_valid got=%h exp=1", inst_valid_o); end
    rst = 1'b1;
    #1;
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL ar_req got=%h exp=0", imem_req_o); end
    checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL ar_valid got=%h exp=0", inst_valid_o); end
    checks++; if (inst_o !== 32'h0000_0013) begin failures++; $display("FAIL ar_inst got=%h exp=00000013", inst_o); end
    checks++; if (inst_addr_o !== 32'h0) begin failures++; $display("FAIL ar_inst_addr got=%h exp=0", inst_addr_o); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
    repeat (6) @(posedge clk);
    checks++;
    if (reqs.size() < 1 || got_a.size() < 1) begin
      failures++; $display("FAIL ar_count reqs=%0d got=%0d exp>=1/1", reqs.size(), got_a.size());
    end else begin
      checks++; if (reqs[0] !== 32'h0) begin failures++; $display("FAIL ar_first_req got=%h exp=0", reqs[0]); end
      checks++; if (got_a[0] !== 32'h0) begin failures++; $display("FAIL ar_first_addr got=%h exp=0", got_a[0]); end
    end
  endtask

  initial begin
    rst = 1'b1; jump_en_i = 1'b0; jump_addr_i = '0; pipeline_flush_i = 1'b0;
    imem_gnt_i = 1'b0; inst_ready_i = 1'b0; mem_en = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_jump_inflight();
    test_jump_align();
    test_flush();
    test_jump_flush_rvalid();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
